// File: rtl/btn_bank.sv
// btn_bank: per-channel 2-flop synchronizer, debouncer FSM, press/release pulses and toggle.
// Long-press detection (long_o) is built only when BTN_BANK_LONG_PRESS_EN is defined.
module btn_bank #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [N_BTN-1:0] toggle_clr_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] pressed_o,
  output logic [N_BTN-1:0] released_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] toggle_o
);

`ifdef BTN_BANK_LONG_PRESS_EN
  localparam int CNT_MAX = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
`else
  localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] lvl_s;

  // Two-stage synchronizer for the raw asynchronous inputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_i;
      sync2_r <= sync1_r;
    end
  end

  assign lvl_s = sync2_r ^ {N_BTN{ACTIVE_LOW}};

`ifdef BTN_BANK_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`else
  // LONG_CYCLES has no effect in this build; long_o is tied low
  localparam logic LONG_TIE = 1'b0 & (LONG_CYCLES > DEBOUNCE_CYCLES);
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             pressed_r;
    logic             released_r;
    logic             toggle_r;
    logic             press_s;

    assign press_s = (state_r == PRESS_WAIT) && lvl_s[g] && (cnt_r == DEB_LAST);

    // Debounce FSM: a new level must hold DEBOUNCE_CYCLES samples in a wait state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_r    <= IDLE;
        cnt_r      <= '0;
        level_r    <= 1'b0;
        pressed_r  <= 1'b0;
        released_r <= 1'b0;
      end else begin
        pressed_r  <= 1'b0;
        released_r <= 1'b0;
        case (state_r)
          IDLE: begin
            cnt_r <= '0;
            if (lvl_s[g]) begin
              state_r <= PRESS_WAIT;
            end else begin
              state_r <= IDLE;
            end
          end
          PRESS_WAIT: begin
            if (!lvl_s[g]) begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end else if (cnt_r == DEB_LAST) begin
              state_r   <= HELD;
              level_r   <= 1'b1;
              pressed_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          HELD: begin
            cnt_r <= '0;
            if (!lvl_s[g]) begin
              state_r <= REL_WAIT;
            end else begin
              state_r <= HELD;
            end
          end
          REL_WAIT: begin
            if (lvl_s[g]) begin
              state_r <= HELD;
              cnt_r   <= '0;
            end else if (cnt_r == DEB_LAST) begin
              state_r    <= IDLE;
              cnt_r      <= '0;
              level_r    <= 1'b0;
              released_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end

    // Clear wins over a flip in the same cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        toggle_r <= 1'b0;
      end else if (toggle_clr_i[g]) begin
        toggle_r <= 1'b0;
      end else if (press_s) begin
        toggle_r <= ~toggle_r;
      end else begin
        toggle_r <= toggle_r;
      end
    end

    assign level_o[g]    = level_r;
    assign pressed_o[g]  = pressed_r;
    assign released_o[g] = released_r;
    assign toggle_o[g]   = toggle_r;

`ifdef BTN_BANK_LONG_PRESS_EN
    logic [CNT_W-1:0] lcnt_r;
    logic             done_r;
    logic             long_r;

    // Long-press count runs only while HELD and pressed, so it freezes in REL_WAIT
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        lcnt_r <= '0;
        done_r <= 1'b0;
        long_r <= 1'b0;
      end else begin
        long_r <= 1'b0;
        if (press_s) begin
          lcnt_r <= '0;
          done_r <= 1'b0;
        end else if ((state_r == HELD) && lvl_s[g]) begin
          if (lcnt_r == LONG_LAST) begin
            if (!done_r) begin
              long_r <= 1'b1;
              done_r <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end else begin
            lcnt_r <= lcnt_r + CNT_ONE;
          end
        end else begin
          lcnt_r <= lcnt_r;
        end
      end
    end

    assign long_o[g] = long_r;
`else
    assign long_o[g] = LONG_TIE;
`endif
  end

endmodule

// File: tb/tb_btn_bank.sv
// Directed + random bench for btn_bank; expected values come from a run-length debounce model.
module tb_btn_bank;
  localparam int N = 5;
  localparam int D = 4;
  localparam int L = 20;
`ifdef BTN_BANK_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] clr = '0;
  logic [N-1:0] level, pressed, released, long_p, toggle;

  btn_bank #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .btn_i(btn), .toggle_clr_i(clr),
    .level_o(level), .pressed_o(pressed), .released_o(released),
    .long_o(long_p), .toggle_o(toggle)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int e0;
  int base;

  // Reference model: raw samples reach the debouncer two edges late; a new level is
  // accepted once it has been seen on D+1 consecutive samples.
  logic [N-1:0] dly0, dly1;
  logic [N-1:0] m_level, m_press, m_rel, m_long, m_tog;
  int run [N];
  int hold [N];
  bit fired [N];
  int press_at [N];
  int rel_at [N];
  int long_at [N];
  int press_cnt [N];
  int long_cnt [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dly0 = '0; dly1 = '0;
    m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_tog = '0;
    for (int c = 0; c < N; c++) begin
      run[c] = 0; hold[c] = 0; fired[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] v;
    v = dly1; dly1 = dly0; dly0 = btn;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      if (v[c] != m_level[c]) begin
        run[c]++;
        if (run[c] == D + 1) begin
          run[c] = 0;
          m_level[c] = v[c];
          if (v[c]) begin
            m_press[c] = 1'b1; hold[c] = 0; fired[c] = 1'b0;
          end else begin
            m_rel[c] = 1'b1;
          end
        end
      end else begin
        if (m_level[c] && run[c] == 0) begin
          hold[c]++;
          if (LONG_EN && hold[c] == L && !fired[c]) begin
            m_long[c] = 1'b1; fired[c] = 1'b1;
          end
        end
        run[c] = 0;
      end
    end
    m_tog = (m_tog ^ m_press) & ~clr;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (rst_n) model_edge();
      @(negedge clk);
      chk("level", 32'(level), 32'(m_level));
      chk("pressed", 32'(pressed), 32'(m_press));
      chk("released", 32'(released), 32'(m_rel));
      chk("long", 32'(long_p), 32'(m_long));
      chk("toggle", 32'(toggle), 32'(m_tog));
      for (int c = 0; c < N; c++) begin
        if (pressed[c] === 1'b1) begin press_at[c] = cyc; press_cnt[c]++; end
        if (released[c] === 1'b1) rel_at[c] = cyc;
        if (long_p[c] === 1'b1) begin long_at[c] = cyc; long_cnt[c]++; end
      end
    end
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < N; c++) begin
      press_at[c] = -1000; rel_at[c] = -1000; long_at[c] = -1000;
      press_cnt[c] = 0; long_cnt[c] = 0;
    end
    step(3);
    rst_n = 1'b1;
    step(2);

    // clean press on channel 0
    btn[0] = 1'b1; e0 = cyc + 1;
    step(10);
    chk("clean_latency", 32'(press_at[0] - e0), 32'd6);
    chk("clean_count", 32'(press_cnt[0]), 32'd1);
    chk("clean_level", 32'(level[0]), 32'd1);
    chk("clean_toggle", 32'(toggle[0]), 32'd1);

    // bounce on channel 1: 1,0,1 at 2-cycle intervals then hold
    btn[1] = 1'b1; step(2);
    btn[1] = 1'b0; step(2);
    btn[1] = 1'b1; e0 = cyc + 1;
    step(12);
    chk("bounce_count", 32'(press_cnt[1]), 32'd1);
    chk("bounce_latency", 32'(press_at[1] - e0), 32'd6);

    // long press on channel 2
    btn[2] = 1'b1; e0 = cyc + 1;
    step(40);
    chk("long_press_latency", 32'(press_at[2] - e0), 32'd6);
`ifdef BTN_BANK_LONG_PRESS_EN
    chk("long_count", 32'(long_cnt[2]), 32'd1);
    chk("long_latency", 32'(long_at[2] - press_at[2]), 32'd20);
`else
    chk("long_disabled", 32'(long_cnt[2]), 32'd0);
`endif
    btn[2] = 1'b0; e0 = cyc + 1;
    step(10);
    chk("long_release_latency", 32'(rel_at[2] - e0), 32'd6);

    // simultaneous press on channels 4:3 with toggle clear on 3 in the pulse cycle
    btn[4:3] = 2'b11; e0 = cyc + 1;
    step(6);
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    chk("simul_pressed", 32'(pressed[4:3]), 32'd3);
    chk("simul_toggle3", 32'(toggle[3]), 32'd0);
    chk("simul_toggle4", 32'(toggle[4]), 32'd1);
    step(1);

    // reset two cycles after a fresh press on channel 0
    btn[0] = 1'b0; step(10);
    btn[0] = 1'b1; e0 = cyc + 1;
    step(7);
    chk("rst_pre_latency", 32'(press_at[0] - e0), 32'd6);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_level", 32'(level), 32'd0);
    chk("rst_async_toggle", 32'(toggle), 32'd0);
    chk("rst_async_pulses", 32'({pressed, released, long_p}), 32'd0);
    step(2);
    rst_n = 1'b1; e0 = cyc + 1; base = press_cnt[0];
    step(8);
    chk("rst_repress_latency", 32'(press_at[0] - e0), 32'd6);
    chk("rst_repress_count", 32'(press_cnt[0] - base), 32'd1);

    // random bouncing traffic with occasional toggle clears
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 11) == 0) btn[c] = ~btn[c];
        clr[c] = ($urandom_range(0, 19) == 0);
      end
      step(1);
    end
    clr = '0;
    btn = '0;
    step(12);
    chk("final_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_bank.md
BTN_BANK -- requirements
Module: btn_bank

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of independent button channels, range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: number of consecutive cycles a new level must hold before it is accepted, minimum 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 50_000_000: number of cycles the debounced level must stay pressed before a long press is reported, greater than DEBOUNCE_CYCLES.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0: when 1, a raw input of 0 means pressed.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port btn_i, input, N_BTN bits: raw asynchronous button inputs.
REQ-008 SHALL have port toggle_clr_i, input, N_BTN bits: synchronous per-channel clear of toggle_o.
REQ-009 SHALL have port level_o, output, N_BTN bits: debounced pressed level, 1 = pressed.
REQ-010 SHALL have port pressed_o, output, N_BTN bits: one-cycle pulse when the debounced level goes to pressed.
REQ-011 SHALL have port released_o, output, N_BTN bits: one-cycle pulse when the debounced level goes to released.
REQ-012 SHALL have port long_o, output, N_BTN bits: one-cycle pulse when a long press is reached.
REQ-013 SHALL have port toggle_o, output, N_BTN bits: per-channel toggle state that flips on each pressed_o.

Function
REQ-014 SHALL pass each btn_i bit through a 2-flop synchronizer, then apply ACTIVE_LOW inversion.
REQ-015 SHALL give each channel its own counter, of width $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)), and its own FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-016 SHALL move IDLE->PRESS_WAIT when the synchronized level is pressed; the counter is cleared on entry.
REQ-017 SHALL, in PRESS_WAIT, return to IDLE with the counter cleared if the level goes released (bounce); otherwise the counter increments.
REQ-018 SHALL, in PRESS_WAIT, move to HELD when the counter reaches DEBOUNCE_CYCLES-1 with the level still pressed; in that same cycle level_o is set, pressed_o pulses, and toggle_o flips.
REQ-019 SHALL, in HELD, move to REL_WAIT when the level is released, and mirror PRESS_WAIT: bounce returns to HELD; on acceptance go to IDLE, clear level_o, pulse released_o.
REQ-020 SHALL make pressed_o pulse exactly DEBOUNCE_CYCLES+2 cycles after the first edge that samples a stable new btn_i value (2 synchronizer cycles + debounce); released_o has the same latency.
REQ-021 SHALL keep a long-press counter in HELD that starts at the pressed_o cycle and saturates; long_o pulses once, LONG_CYCLES cycles after pressed_o, and never re-fires until the channel has been released.
REQ-022 SHALL leave the long-press count frozen while in REL_WAIT; a bounce back to HELD resumes it without reset.
REQ-023 SHALL process channels fully independently; simultaneous events on several channels all produce pulses in the same cycle, with no priority.
REQ-024 SHALL give toggle_clr_i priority over a simultaneous toggle flip, so toggle_o ends at 0.
REQ-025 SHALL drive all outputs from registers.

Reset
REQ-026 SHALL, on rst_n_i low, immediately force the FSM to IDLE, all counters and synchronizer flops to 0, and level_o, pressed_o, released_o, long_o, toggle_o to 0.
REQ-027 SHALL, when rst_n_i is asserted mid-debounce or mid-hold, emit no pulse; after release from reset a button still held is re-debounced from IDLE and produces a fresh pressed_o.

Configuration
REQ-028 SHALL gate long-press detection with macro BTN_BANK_LONG_PRESS_EN.
REQ-029 SHALL, when BTN_BANK_LONG_PRESS_EN is defined, implement long-press counting and long_o per REQ-021/022.
REQ-030 SHALL, when BTN_BANK_LONG_PRESS_EN is undefined, drive long_o to constant 0, size the counter by DEBOUNCE_CYCLES only, and ignore LONG_CYCLES.

Verification
REQ-031 SHALL cover clean press (N_BTN=5, DEBOUNCE_CYCLES=4, btn_i[0] 0->1 held): pressed_o[0] pulses exactly 6 cycles later, level_o[0]=1, toggle_o[0]=1.
REQ-032 SHALL cover bounce: btn_i[1] toggles 1,0,1 at 2-cycle intervals then holds 1 -> exactly one pressed_o[1], 6 cycles after the final rising sample.
REQ-033 SHALL cover long press (LONG_CYCLES=20, macro defined): hold btn_i[2] for 40 cycles -> long_o[2] pulses once, 20 cycles after pressed_o[2]; release -> released_o[2] 6 cycles later.
REQ-034 SHALL cover simultaneous events: btn_i[4:3] rise together while toggle_clr_i[3]=1 in the pulse cycle -> both pressed_o pulse, toggle_o[3]=0, toggle_o[4]=1.
REQ-035 SHALL cover reset mid-hold: assert rst_n_i low 2 cycles after pressed_o[0] with the button held -> outputs are 0 asynchronously; after deassertion, pressed_o[0] pulses again 6 cycles later.
REQ-036 SHALL cover the macro undefined: repeat the REQ-033 stimulus -> long_o stays 0 for all cycles.
